// File: rtl/vc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : vc_fifo_pkg
// Brief  : Default sizing constants and shared typedefs for vc_sync_fifo.
// Rev    : 1.0 - initial release
// ============================================================================
package vc_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_NUM_VC    = 4;
  localparam int DEF_AF_THRESH = 12;

  typedef logic [DEF_WIDTH-1:0]           flit_t;
  typedef logic [$clog2(DEF_NUM_VC)-1:0]  vc_id_t;

endpackage : vc_fifo_pkg
`default_nettype wire

// File: rtl/vc_fifo_lane.sv
`default_nettype none
// ============================================================================
// Module : vc_fifo_lane
// Brief  : One virtual-channel ring buffer with count-derived status flags.
//          Optional sticky error flags under VC_SYNC_FIFO_ERR_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module vc_fifo_lane #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
`ifdef VC_SYNC_FIFO_ERR_EN
  ,
  output logic             overflow_err,
  output logic             underflow_err
`endif
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   AF_CNT   = (PTR_W + 1)'(AF_THRESH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the ring.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign wr_acc = wr_req && !full;
  assign rd_acc = rd_req && !empty;
  assign head   = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (wr_acc && !rd_acc)
      cnt_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc)
        rd_ptr <= ptr_inc(rd_ptr);
      count       <= cnt_nxt;
      full        <= (cnt_nxt == FULL_CNT);
      empty       <= (cnt_nxt == '0);
      almost_full <= (cnt_nxt >= AF_CNT);
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wr_ptr] <= wr_data;
  end

`ifdef VC_SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_req && full)
        overflow_err <= 1'b1;
      if (rd_req && empty)
        underflow_err <= 1'b1;
    end
  end
`endif

endmodule : vc_fifo_lane
`default_nettype wire

// File: rtl/vc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : vc_sync_fifo
// Brief  : Multi-VC synchronous FIFO: shared write/read ports, per-VC queues,
//          registered read data. Define VC_SYNC_FIFO_ERR_EN for error flags.
// Rev    : 1.0 - initial release
// ============================================================================
module vc_sync_fifo
  import vc_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_VC    = DEF_NUM_VC,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int VC_W      = $clog2(NUM_VC)
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        WR_EN,
  input  logic [VC_W-1:0]             WR_VC,
  input  logic [WIDTH-1:0]            DATA_IN,
  input  logic                        RD_EN,
  input  logic [VC_W-1:0]             RD_VC,
  output logic [WIDTH-1:0]            DATA_OUT,
  output logic                        RD_VALID,
  output logic [NUM_VC-1:0]           FIFO_FULL,
  output logic [NUM_VC-1:0]           FIFO_EMPTY,
  output logic [NUM_VC-1:0]           ALMOST_FULL,
  output logic [NUM_VC*(PTR_W+1)-1:0] VC_COUNT
`ifdef VC_SYNC_FIFO_ERR_EN
  ,
  output logic [NUM_VC-1:0]           OVERFLOW_ERR,
  output logic [NUM_VC-1:0]           UNDERFLOW_ERR
`endif
);

  logic [NUM_VC-1:0] wr_req;
  logic [NUM_VC-1:0] rd_req;
  logic [NUM_VC-1:0] rd_acc;
  logic [WIDTH-1:0]  head [NUM_VC];
  logic [WIDTH-1:0]  head_sel;
  logic              rd_hit;

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
      assign wr_req[v] = WR_EN && (WR_VC == VC_W'(v));
      assign rd_req[v] = RD_EN && (RD_VC == VC_W'(v));

      vc_fifo_lane #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .PTR_W     (PTR_W)
      ) u_lane (
        .clk         (CLK),
        .rst_n       (RSTn),
        .wr_req      (wr_req[v]),
        .wr_data     (DATA_IN),
        .rd_req      (rd_req[v]),
        .head        (head[v]),
        .count       (VC_COUNT[v*(PTR_W+1) +: PTR_W+1]),
        .full        (FIFO_FULL[v]),
        .empty       (FIFO_EMPTY[v]),
        .almost_full (ALMOST_FULL[v])
`ifdef VC_SYNC_FIFO_ERR_EN
        ,
        .overflow_err  (OVERFLOW_ERR[v]),
        .underflow_err (UNDERFLOW_ERR[v])
`endif
      );
    end
  endgenerate

  // Decoding per lane keeps out-of-range VC selects harmless: they hit nothing.
  assign rd_acc = rd_req & ~FIFO_EMPTY;
  assign rd_hit = |rd_acc;

  always_comb begin
    head_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_acc[v])
        head_sel = head[v];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      DATA_OUT <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= rd_hit;
      if (rd_hit)
        DATA_OUT <= head_sel;
    end
  end

endmodule : vc_sync_fifo
`default_nettype wire

// File: doc/vc_sync_fifo.md
Name: vc_sync_fifo

Overview:
Parametrised successor to the single-queue synchronous FIFO, for the router input port.
- NUM_VC independent virtual-channel queues share one write port and one read port; each cycle selects one VC to write and one to read.
- Adds per-VC occupancy counts, per-VC almost-full flags, a registered read-data valid strobe, and arbitrary (non-power-of-two) depth.
- Sits between link receiver and switch allocator; status flags drive upstream credit/flow control.

Parameters:
WIDTH, 8, flit data width in bits
DEPTH, 16, entries per VC queue; any value >= 2
NUM_VC, 4, number of virtual-channel queues; >= 2
AF_THRESH, 12, per-VC count at/above which ALMOST_FULL[v] asserts; 1..DEPTH
PTR_W, $clog2(DEPTH), pointer width (derived)
VC_W, $clog2(NUM_VC), VC select width (derived)

Ports:
CLK  in  1  clock; all logic on rising edge
RSTn  in  1  reset, synchronous, active-low
WR_EN  in  1  write request
WR_VC  in  VC_W  target VC for write
DATA_IN  in  WIDTH  write data
RD_EN  in  1  read request
RD_VC  in  VC_W  source VC for read
DATA_OUT  out  WIDTH  read data, registered
RD_VALID  out  1  DATA_OUT holds data popped the previous cycle
FIFO_FULL  out  NUM_VC  per-VC full
FIFO_EMPTY  out  NUM_VC  per-VC empty
ALMOST_FULL  out  NUM_VC  per-VC count >= AF_THRESH
VC_COUNT  out  NUM_VC*(PTR_W+1)  packed per-VC occupancy; VC v at [v*(PTR_W+1) +: PTR_W+1]

Behaviour:
- Reset: RSTn sampled low at a rising edge clears all pointers and counts to 0 and sets DATA_OUT=0, RD_VALID=0, FIFO_EMPTY=all 1, FIFO_FULL=0, ALMOST_FULL=0, VC_COUNT=0. Reset mid-operation discards all queued data; storage contents need not be cleared. Reset has priority over WR_EN/RD_EN.
- Storage: per VC, a DEPTH-entry ring. wr_ptr/rd_ptr advance DEPTH-1 -> 0 by explicit compare, with no reliance on power-of-two wrap. Full and empty are derived from count, not pointer equality.
- Write: accepted iff WR_EN && !FIFO_FULL[WR_VC] at the edge. On accept, mem[WR_VC][wr_ptr] <= DATA_IN, wr_ptr++, and count++ (net of a same-VC read).
- Read: accepted iff RD_EN && !FIFO_EMPTY[RD_VC]. On accept, DATA_OUT <= head entry next edge, RD_VALID=1 for exactly that cycle, rd_ptr++, count--. A rejected or absent read gives RD_VALID=0 with DATA_OUT holding its last value.
- Read latency: 1 cycle from the accepting edge to DATA_OUT/RD_VALID.
- Flags are registered with the count, so they reflect state after the last edge (no combinational path from WR_EN/RD_EN to flags).
- Simultaneous write and read, different VCs: both proceed independently.
- Simultaneous write and read, same VC, neither full nor empty: both proceed; count unchanged.
- Same VC, empty: read rejected, write accepted; no fall-through, the new flit is readable from the next cycle.
- Same VC, full: write rejected (dropped), read accepted; count becomes DEPTH-1. Upstream must honour FIFO_FULL/credits.
- Rejected writes and reads change no state.
- Ordering: strict FIFO within a VC; no ordering between VCs.

Optional Feature:
Macro VC_SYNC_FIFO_ERR_EN.
- Defined: adds outputs OVERFLOW_ERR[NUM_VC] and UNDERFLOW_ERR[NUM_VC], sticky per VC. Set on a rejected write (full) or rejected read (empty) to that VC; cleared only by reset.
- Undefined: these ports and their logic are absent; rejected operations are silent.

Decomposition:
- Package vc_fifo_pkg holds default WIDTH/DEPTH/NUM_VC constants, the flit_t typedef (logic [WIDTH-1:0]), and the vc_id_t typedef.
- One sub-module, vc_fifo_lane: a single-VC ring buffer with count, full/empty/almost-full, and ERR logic. It is instantiated NUM_VC times via generate.
- Top level does write/read VC demux, head-data mux, DATA_OUT/RD_VALID registers, and VC_COUNT packing.

Test Plan:
- Reset, then idle -> FIFO_EMPTY=4'b1111, FIFO_FULL=0, VC_COUNT=0, RD_VALID=0.
- Write 0x00..0x0F to VC2 -> FIFO_FULL[2]=1 after the 16th, ALMOST_FULL[2]=1 from the 12th write; a 17th write (0xAA) is dropped (ERR_EN: OVERFLOW_ERR[2]=1); then 16 reads of VC2 return 0x00..0x0F in order, each 1 cycle after request, with RD_VALID pulses.
- Interleave writes to VC0 (0x10..0x13) and VC3 (0x30..0x33), then read VC3 then VC0 -> 0x30..0x33 then 0x10..0x13; other VCs' counts stay 0.
- VC1 holding 8 entries, 8 cycles of simultaneous write (0x80..0x87) and read on VC1 -> count stays 8, reads return the original 8 flits; then drain returns 0x80..0x87.
- Simultaneous write to empty VC0 and read of VC0 -> read rejected, RD_VALID=0 (ERR_EN: UNDERFLOW_ERR[0]=1); count becomes 1; next-cycle read returns the written data.
- Fill VC1 with 5 entries, assert RSTn=0 for one edge mid-burst -> all flags/counts return to reset values; a subsequent read of VC1 is rejected.
